// File: rtl/div_unit.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU; stalls EX while busy.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_rem,
  input  logic [1:0]       signed_unsigned,
  input  logic             kill,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             stall
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN, S_DONE} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q, result_q;
  logic             is_rem_q, q_neg_q, r_neg_q, div0_q, ovf_q;

  logic             dvd_neg, dsr_neg, div0, ovf, early;
  logic [WIDTH-1:0] dvd_abs, dsr_abs, quo_fix, rem_fix, early_res;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic             unused_mode;

  assign unused_mode = signed_unsigned[1];

  // Operand magnitudes and special-case detection at acceptance
  assign dvd_neg = ~signed_unsigned[0] & dividend[WIDTH-1];
  assign dsr_neg = ~signed_unsigned[0] & divisor[WIDTH-1];
  assign dvd_abs = dvd_neg ? -dividend : dividend;
  assign dsr_abs = dsr_neg ? -divisor : divisor;
  assign div0    = (divisor == '0);
  assign ovf     = ~signed_unsigned[0] & (dividend == MIN_NEG) & (divisor == '1);
  assign early_res = div0 ? (is_rem ? dividend : '1) : (is_rem ? '0 : MIN_NEG);

`ifdef DIV_EARLY_OUT_EN
  assign early = div0 | ovf;
`else
  assign early = 1'b0;
`endif

  // One restoring step: the (WIDTH+1)-bit difference's MSB is the borrow
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dsr_q};
  assign rem_d  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_d  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

  // Divide-by-zero remainder falls out naturally: |dividend| re-signed by r_neg
  assign quo_fix = ovf_q ? MIN_NEG : (div0_q ? '1 : (q_neg_q ? -quo_q : quo_q));
  assign rem_fix = ovf_q ? '0 : (r_neg_q ? -rem_q : rem_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      result_q <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (kill) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_rem_q <= is_rem;
            q_neg_q  <= dvd_neg ^ dsr_neg;
            r_neg_q  <= dvd_neg;
            div0_q   <= div0;
            ovf_q    <= ovf;
            quo_q    <= dvd_abs;
            dsr_q    <= dsr_abs;
            rem_q    <= '0;
            cnt_q    <= '0;
            if (early) begin
              result_q <= early_res;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_SIGN;
        end
        S_SIGN: begin
          result_q <= is_rem_q ? rem_fix : quo_fix;
          state_q  <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign done   = (state_q == S_DONE);
  assign busy   = (state_q == S_RUN) | (state_q == S_SIGN);
  assign stall  = ~rst & ((start & (state_q == S_IDLE) & ~kill) | busy);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit (default build: every operation takes the full path).
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, is_rem, kill;
  logic [1:0]  su;
  logic [31:0] dividend, divisor, result;
  logic        done, busy, stall;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int last_done = 0;
  logic [31:0] prev_res = '0;
  logic [31:0] sb_q[$];

  localparam int LAT = 34;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_rem(is_rem),
    .signed_unsigned(su), .kill(kill), .dividend(dividend), .divisor(divisor),
    .result(result), .done(done), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic rem, input logic uns,
                                         input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (uns) return rem ? (a % b) : (a / b);
    sa = a;
    sb = b;
    return rem ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  // Drive one operation, scramble operands after acceptance, wait for done.
  task automatic do_op(input string tag, input logic rem, input logic uns,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic tim);
    int t0;
    bit got;
    logic [31:0] e;
    @(negedge clk);
    start = 1'b1; is_rem = rem; su = {1'($urandom), uns};
    dividend = a; divisor = b;
    sb_q.push_back(exp);
    t0 = cyc;
    #1;
    if (tim) begin
      check({tag, " stall c0"}, 32'(stall), 32'd1);
      check({tag, " busy c0"}, 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    start = 1'b0; is_rem = ~rem; su = {1'b0, ~uns};
    dividend = $urandom; divisor = $urandom;
    got = 0;
    for (int k = 1; k <= LAT + 5 && !got; k++) begin
      @(negedge clk);
      if (tim) begin
        check($sformatf("%s stall c%0d", tag, k), 32'(stall), 32'(k < LAT));
        check($sformatf("%s busy c%0d", tag, k), 32'(busy), 32'(k < LAT));
        check($sformatf("%s done c%0d", tag, k), 32'(done), 32'(k == LAT));
      end
      if (done) begin
        got = 1;
        check({tag, " latency"}, 32'(cyc - t0), 32'(LAT));
        e = sb_q.pop_front();
        check({tag, " result"}, result, e);
        prev_res = e;
        last_done = cyc;
      end
    end
    if (!got) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    int t0, n_done, d1;
    logic rr, uu;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b1; is_rem = 1'b0; kill = 1'b0; su = 2'b00;
    dividend = 32'd5; divisor = 32'd1;
    repeat (3) @(negedge clk);
    check("reset result", result, 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    start = 1'b0;
    rst = 1'b0;

    do_op("div -20/3", 1'b0, 1'b0, -32'sd20, 32'd3, 32'hFFFF_FFFA, 1'b1);
    do_op("rem -20%3", 1'b1, 1'b0, -32'sd20, 32'd3, 32'hFFFF_FFFE, 1'b0);
    do_op("divu", 1'b0, 1'b1, 32'hFFFF_FFEC, 32'd3, 32'h5555_554E, 1'b0);
    do_op("remu", 1'b1, 1'b1, 32'hFFFF_FFEC, 32'd3, 32'h0000_0002, 1'b0);
    do_op("div 7/0", 1'b0, 1'b0, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op("rem 7/0", 1'b1, 1'b0, 32'd7, 32'd0, 32'h0000_0007, 1'b0);
    do_op("rem -7/0", 1'b1, 1'b0, -32'sd7, 32'd0, 32'hFFFF_FFF9, 1'b0);
    do_op("div ovf", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op("rem ovf", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    do_op("divu ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rr = 1'($urandom); uu = 1'($urandom);
      a = $urandom;
      b = (i < 3) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 2) b = -32'sd9;
      do_op($sformatf("rand%0d", i), rr, uu, a, b, ref_op(rr, uu, a, b), 1'b0);
    end

    // Kill mid-run: no done, result untouched
    @(negedge clk);
    start = 1'b1; is_rem = 1'b0; su = 2'b00; dividend = 32'd1000; divisor = 32'd3;
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc < t0 + 10) @(negedge clk);
    check("kill busy before", 32'(busy), 32'd1);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill busy after", 32'(busy), 32'd0);
    check("kill stall after", 32'(stall), 32'd0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("kill no done", 32'(n_done), 32'd0);
    check("kill result kept", result, prev_res);
    do_op("divu after kill", 1'b0, 1'b1, 32'd100, 32'd7, 32'h0000_000E, 1'b0);

    // Asynchronous reset mid-run clears outputs immediately
    @(negedge clk);
    start = 1'b1; is_rem = 1'b0; su = 2'b01; dividend = 32'd999; divisor = 32'd4;
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc < t0 + 20) @(negedge clk);
    #2 rst = 1'b1; start = 1'b1;
    #1;
    check("rst result", result, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    prev_res = '0;

    // Back-to-back: second start in the cycle after DONE
    do_op("b2b div", 1'b0, 1'b0, 32'd100, 32'd7, 32'h0000_000E, 1'b0);
    d1 = last_done;
    do_op("b2b rem", 1'b1, 1'b0, 32'd100, 32'd7, 32'h0000_0002, 1'b0);
    check("b2b spacing", 32'(last_done - d1), 32'd35);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
